// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding used by the controller, display and bench.
// No logic here; constants and types only, no backpressure.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } sw_state_e;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button levels in, counter/display controls out; master is the controller side.
// Pure wiring, no latency, no backpressure.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic       start_db;
    logic       lap_db;
    logic       count_en;
    logic       count_clr;
    logic       disp_freeze;
    logic       running;
    logic [1:0] state;

    modport master (
        input  start_db, lap_db,
        output count_en, count_clr, disp_freeze, running, state
    );

    modport slave (
        output start_db, lap_db,
        input  count_en, count_clr, disp_freeze, running, state
    );
endinterface

// File: rtl/stopwatch_ctrl_one_pulse.sv
// Level-to-press converter: pulse_out is high for one cycle, one clock after the level rises.
// History resets to 1 so a button held through reset gives no press; no backpressure.
module one_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic level_in,
    output logic pulse_out
);
    logic in_r_q, in_r_d;
    logic in_p_q, in_p_d;

    always_comb begin
        in_r_d = level_in;
        in_p_d = in_r_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_r_q <= 1'b1;
            in_p_q <= 1'b1;
        end else begin
            in_r_q <= in_r_d;
            in_p_q <= in_p_d;
        end
    end

    assign pulse_out = in_r_q & ~in_p_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM with tick prescaler; outputs change two clocks after a button rise.
// All outputs registered; no backpressure, the counter must accept every strobe.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1_000_000,
    parameter int unsigned PW       = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    stopwatch_ctrl_if.master  sw
);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic      start_p, lap_p;
    logic      active, wrap;

    sw_state_e     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          count_en_q, count_en_d;
    logic          count_clr_q, count_clr_d;
    logic          freeze_q, freeze_d;
    logic          running_q, running_d;

    one_pulse u_start (.clk(clk), .rst_n(rst_n), .level_in(sw.start_db), .pulse_out(start_p));
    one_pulse u_lap   (.clk(clk), .rst_n(rst_n), .level_in(sw.lap_db),   .pulse_out(lap_p));

    always_comb begin
        active      = (state_q == S_RUN) || (state_q == S_LAP);
        wrap        = active && (presc_q == PRE_MAX);
        state_d     = state_q;
        presc_d     = presc_q;
        count_clr_d = 1'b0;

        // PAUSE holds the partial tick so a resume continues mid-period.
        if (active)
            presc_d = wrap ? '0 : presc_q + PW'(1);
        else if (state_q == S_IDLE)
            presc_d = '0;

        // Start is decoded first, so a coincident lap press is dropped.
        case (state_q)
            S_IDLE: begin
                if (start_p)    state_d = S_RUN;
                else if (lap_p) count_clr_d = 1'b1;
            end
            S_RUN: begin
                if (start_p)    state_d = S_PAUSE;
                else if (lap_p) state_d = S_LAP;
            end
            S_LAP: begin
                if (start_p)    state_d = S_PAUSE;
                else if (lap_p) state_d = S_RUN;
            end
            S_PAUSE: begin
                if (start_p) begin
                    state_d = S_RUN;
                end else if (lap_p) begin
                    state_d     = S_IDLE;
                    count_clr_d = 1'b1;
                    presc_d     = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A start press in RUN/LAP always leaves; the wrap it coincides with is not counted.
        count_en_d = wrap && !start_p;
        freeze_d   = (state_d == S_LAP);
        running_d  = (state_d == S_RUN) || (state_d == S_LAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
            freeze_q    <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            count_en_q  <= count_en_d;
            count_clr_q <= count_clr_d;
            freeze_q    <= freeze_d;
            running_q   <= running_d;
        end
    end

    assign sw.state       = state_q;
    assign sw.count_en    = count_en_q;
    assign sw.count_clr   = count_clr_q;
    assign sw.disp_freeze = freeze_q;
    assign sw.running     = running_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl at TICK_DIV=4: directed vector table, async reset, then random levels vs a model.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int TD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stopwatch_ctrl_if sw();

    stopwatch_ctrl #(.TICK_DIV(TD), .PW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw)
    );

    typedef struct {
        logic       s;
        logic       l;
        logic [1:0] st;
        logic       en;
        logic       clr;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model state
    logic       m_sr, m_sp, m_lr, m_lp;
    logic [1:0] m_st;
    int         m_pc;

    function automatic logic [5:0] exp_bits(vec_t e);
        return {e.st, e.en, e.clr, (e.st == 2'b11), (e.st == 2'b01 || e.st == 2'b11)};
    endfunction

    function automatic logic [5:0] dut_bits();
        return {sw.state, sw.count_en, sw.count_clr, sw.disp_freeze, sw.running};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {st,en,clr,frz,run}=%b expected %b", name, act, exp);
    endtask

    task automatic v(input logic s, input logic l, input logic [1:0] st,
                     input logic en, input logic clr);
        vec_t e;
        e.s = s; e.l = l; e.st = st; e.en = en; e.clr = clr;
        tbl.push_back(e);
    endtask

    task automatic step(input string name, input vec_t e);
        vec_t got;
        sw.start_db = e.s;
        sw.lap_db   = e.l;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check(name, dut_bits(), exp_bits(got));
    endtask

    task automatic model_reset();
        m_sr = 1'b1; m_sp = 1'b1; m_lr = 1'b1; m_lp = 1'b1;
        m_st = 2'b00;
        m_pc = 0;
    endtask

    task automatic model_step(input logic s, input logic l, output vec_t e);
        logic ps, pl, act, wrap;
        ps   = m_sr & ~m_sp;
        pl   = m_lr & ~m_lp;
        act  = (m_st == 2'b01) || (m_st == 2'b11);
        wrap = act && (m_pc == TD - 1);
        e.s = s; e.l = l;
        e.en  = wrap && !ps;
        e.clr = 1'b0;
        if (act)                m_pc = wrap ? 0 : m_pc + 1;
        else if (m_st == 2'b00) m_pc = 0;
        if (ps) begin
            m_st = (m_st == 2'b00 || m_st == 2'b10) ? 2'b01 : 2'b10;
        end else if (pl) begin
            case (m_st)
                2'b00: e.clr = 1'b1;
                2'b01: m_st = 2'b11;
                2'b11: m_st = 2'b01;
                default: begin m_st = 2'b00; e.clr = 1'b1; m_pc = 0; end
            endcase
        end
        m_sp = m_sr; m_sr = s;
        m_lp = m_lr; m_lr = l;
        e.st = m_st;
    endtask

    initial begin
        vec_t e;
        logic s, l;
        sw.start_db = 1'b1;
        sw.lap_db   = 1'b0;

        // start held through reset: no press until released and pressed again
        v(1,0,S_IDLE,0,0); v(1,0,S_IDLE,0,0); v(0,0,S_IDLE,0,0); v(0,0,S_IDLE,0,0);
        v(1,0,S_IDLE,0,0); v(1,0,S_RUN,0,0);
        // 12 clocks in RUN: strobe on every 4th
        for (int k = 0; k < 3; k++) begin
            v(0,0,S_RUN,0,0); v(0,0,S_RUN,0,0); v(0,0,S_RUN,0,0); v(0,0,S_RUN,1,0);
        end
        // lap freeze and release, counting continues
        v(0,1,S_RUN,0,0); v(0,1,S_LAP,0,0); v(0,0,S_LAP,0,0); v(0,0,S_LAP,1,0);
        v(0,1,S_LAP,0,0); v(0,0,S_RUN,0,0); v(0,0,S_RUN,0,0); v(0,0,S_RUN,1,0);
        // pause with prescaler at 2, resume keeps the partial tick
        v(0,0,S_RUN,0,0); v(1,0,S_RUN,0,0); v(0,0,S_PAUSE,0,0);
        for (int k = 0; k < 10; k++) v(0,0,S_PAUSE,0,0);
        v(1,0,S_PAUSE,0,0); v(0,0,S_RUN,0,0); v(0,0,S_RUN,1,0); v(0,0,S_RUN,0,0);
        // pause then lap clears; lap in IDLE pulses clear again
        v(1,0,S_RUN,0,0); v(0,0,S_PAUSE,0,0); v(0,1,S_PAUSE,0,0); v(0,0,S_IDLE,0,1);
        v(0,0,S_IDLE,0,0); v(0,1,S_IDLE,0,0); v(0,0,S_IDLE,0,1); v(0,0,S_IDLE,0,0);
        // fresh start: first strobe a full period after entering RUN
        v(1,0,S_IDLE,0,0); v(0,0,S_RUN,0,0);
        v(0,0,S_RUN,0,0); v(0,0,S_RUN,0,0); v(0,0,S_RUN,0,0); v(0,0,S_RUN,1,0);
        // simultaneous start+lap: start wins
        v(1,1,S_RUN,0,0); v(0,0,S_PAUSE,0,0); v(0,0,S_PAUSE,0,0);
        // start press landing on a wrap suppresses the strobe
        v(1,0,S_PAUSE,0,0); v(0,0,S_RUN,0,0); v(1,0,S_RUN,0,0); v(0,0,S_PAUSE,0,0);
        v(0,0,S_PAUSE,0,0); v(1,0,S_PAUSE,0,0); v(0,0,S_RUN,0,0); v(0,0,S_RUN,0,0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_values", dut_bits(), 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // asynchronous reset mid-RUN, observed before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_bits(), 6'b000000);
        sw.start_db = 1'b1;
        sw.lap_db   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // held start after reset must not start; then random button levels
        s = 1'b1;
        l = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i >= 4) begin
                if ($urandom_range(3) == 0) s = ~s;
                if ($urandom_range(4) == 0) l = ~l;
            end
            model_step(s, l, e);
            step($sformatf("rand%0d", i), e);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
